// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: sequences obstacle IDs through gap/start/run phases, one per round.
// Define RANDOM_ORDER_EN to pick IDs from an 8-bit LFSR instead of round-robin order.
module obstacle_scheduler #(
  parameter int unsigned NUM_OBSTACLES = 4,
  parameter int unsigned GAP_FRAMES    = 60,
  parameter int unsigned RUN_FRAMES    = 600
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       game_on,
  input  logic       menu_on,
  input  logic       play_selected,
  input  logic       frame_tick,
  input  logic       obstacle_done,
  output logic [3:0] selected,
  output logic       obstacle_start,
  output logic       timeout,
  output logic [7:0] round_count,
  output logic       busy
);

  localparam int unsigned MaxFrames = (GAP_FRAMES > RUN_FRAMES) ? GAP_FRAMES : RUN_FRAMES;
  localparam int unsigned CntW      = $clog2(MaxFrames + 1);

  localparam logic [CntW-1:0] GapLast = CntW'(GAP_FRAMES - 1);
  localparam logic [CntW-1:0] RunLast = CntW'(RUN_FRAMES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StStart,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      selected_q, selected_d;
  logic            start_q, start_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      round_q, round_d;
  logic            busy_q, busy_d;
  logic [3:0]      prev_q, prev_d;

  logic [3:0]      rr_id;
  logic [3:0]      next_id;
  logic [7:0]      round_inc;
  logic            abort;

  always_comb begin
    rr_id = 4'((prev_q % 4'(NUM_OBSTACLES)) + 4'd1);
  end

`ifdef RANDOM_ORDER_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] rnd_id;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1.
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rnd_id  = 4'((lfsr_q % 8'(NUM_OBSTACLES)) + 8'd1);
    next_id = (rnd_id == prev_q) ? rr_id : rnd_id;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_comb begin
    next_id = rr_id;
  end
`endif

  always_comb begin
    abort     = menu_on || !game_on;
    round_inc = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    selected_d = selected_q;
    start_d    = 1'b0;
    timeout_d  = 1'b0;
    round_d    = round_q;
    busy_d     = busy_q;
    prev_d     = prev_q;

    // Leaving the game screen beats any done/timeout event in the same cycle.
    if (state_q != StIdle && abort) begin
      state_d    = StIdle;
      cnt_d      = '0;
      selected_d = 4'd0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          selected_d = 4'd0;
          busy_d     = 1'b0;
          if (game_on && play_selected && !menu_on) begin
            state_d = StGap;
            cnt_d   = '0;
            round_d = 8'd0;
          end
        end
        StGap: begin
          if (frame_tick) begin
            if (cnt_q == GapLast) begin
              state_d    = StStart;
              cnt_d      = '0;
              selected_d = next_id;
              prev_d     = next_id;
              start_d    = 1'b1;
              busy_d     = 1'b1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StStart: begin
          state_d = StRun;
          cnt_d   = '0;
        end
        StRun: begin
          if (obstacle_done) begin
            state_d    = StGap;
            cnt_d      = '0;
            selected_d = 4'd0;
            busy_d     = 1'b0;
            round_d    = round_inc;
          end else if (frame_tick) begin
            if (cnt_q == RunLast) begin
              state_d    = StGap;
              cnt_d      = '0;
              selected_d = 4'd0;
              busy_d     = 1'b0;
              timeout_d  = 1'b1;
              round_d    = round_inc;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      selected_q <= 4'd0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
      round_q    <= 8'd0;
      busy_q     <= 1'b0;
      prev_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      selected_q <= selected_d;
      start_q    <= start_d;
      timeout_q  <= timeout_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      prev_q     <= prev_d;
    end
  end

  assign selected       = selected_q;
  assign obstacle_start = start_q;
  assign timeout        = timeout_q;
  assign round_count    = round_q;
  assign busy           = busy_q;

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have parameter NUM_OBSTACLES, default 4, number of obstacle IDs in rotation (legal 1..15).
REQ-002 SHALL have parameter GAP_FRAMES, default 60, idle frames between obstacles (legal >=1).
REQ-003 SHALL have parameter RUN_FRAMES, default 600, frame timeout for one obstacle (legal >=1).
REQ-004 SHALL have port pclk, input, 1, pixel clock; the only clock.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port game_on, input, 1, game screen active.
REQ-007 SHALL have port menu_on, input, 1, menu screen active.
REQ-008 SHALL have port play_selected, input, 1, player chose PLAY.
REQ-009 SHALL have port frame_tick, input, 1, one-pclk pulse per video frame.
REQ-010 SHALL have port obstacle_done, input, 1, one-pclk pulse from the active obstacle module when its pattern ends.
REQ-011 SHALL have port selected, output, 4, active obstacle ID (1..NUM_OBSTACLES, 0 = none; lasers = 4'b0011).
REQ-012 SHALL have port obstacle_start, output, 1, one-pclk pulse on the first cycle a new ID is driven.
REQ-013 SHALL have port timeout, output, 1, one-pclk pulse when a run ends by RUN_FRAMES expiry.
REQ-014 SHALL have port round_count, output, 8, completed obstacles since game start.
REQ-015 SHALL have port busy, output, 1, high in START and RUN.

Function
REQ-016 SHALL implement states IDLE, GAP, START, RUN; all outputs registered.
REQ-017 IDLE: selected=0; SHALL go to GAP when game_on && play_selected && !menu_on; clears round_count and frame counter on entry to GAP from IDLE.
REQ-018 GAP: frame counter increments on frame_tick; on frame_tick with count==GAP_FRAMES-1 SHALL go to START and latch next ID.
REQ-019 START: lasts exactly one cycle; selected=next ID and obstacle_start=1 in the same registered cycle; then RUN, counter cleared.
REQ-020 RUN: selected held; obstacle_done SHALL end the run -> GAP, selected=0 next cycle, round_count+1.
REQ-021 RUN: on frame_tick with count==RUN_FRAMES-1 and no obstacle_done SHALL pulse timeout, -> GAP, round_count+1.
REQ-022 obstacle_done and timeout-frame_tick in the same cycle SHALL count as done; timeout stays 0.
REQ-023 obstacle_done outside RUN SHALL be ignored.
REQ-024 In any non-IDLE state, menu_on=1 or game_on=0 SHALL abort to IDLE next cycle: selected=0, busy=0, no timeout pulse, round_count held; abort has priority over done and timeout.
REQ-025 round_count SHALL saturate at 255.
REQ-026 Next ID (default order): round-robin, first ID 1, then prev%NUM_OBSTACLES+1.
REQ-027 Counters SHALL be wide enough for max(GAP_FRAMES, RUN_FRAMES) with no wrap.

Reset
REQ-028 On rst: state=IDLE, selected=0, obstacle_start=0, timeout=0, busy=0, round_count=0, counters=0, previous ID=0, LFSR=8'hA5.
REQ-029 rst asserted mid-RUN SHALL override all other inputs in that cycle.

Configuration
REQ-030 Macro RANDOM_ORDER_EN defined: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advances every pclk outside reset; next ID = (lfsr mod NUM_OBSTACLES)+1, replaced by prev%NUM_OBSTACLES+1 if equal to previous ID (no immediate repeat when NUM_OBSTACLES>1).
REQ-031 Macro RANDOM_ORDER_EN undefined: LFSR absent, round-robin per REQ-026.

Verification (GAP_FRAMES=2, RUN_FRAMES=3, NUM_OBSTACLES=4, macro undefined unless stated)
REQ-032 rst, then game_on=play_selected=1, menu_on=0, 2 frame_ticks -> obstacle_start pulse, selected=1, busy=1.
REQ-033 In RUN, obstacle_done pulse -> next cycle selected=0, round_count=1; 2 further ticks -> selected=2; continues 3,4,1.
REQ-034 In RUN, 3 frame_ticks no done -> timeout pulse exactly once, selected=0, round_count+1.
REQ-035 Third tick coincident with obstacle_done -> no timeout, round_count+1.
REQ-036 menu_on=1 mid-RUN -> IDLE next cycle, selected=0, round_count held; rst mid-RUN -> all REQ-028 values.
REQ-037 RANDOM_ORDER_EN defined, 50 rounds -> selected always 1..4, never equal to previous ID.
